// File: rtl/fp_pkg.sv
// Shared definitions for the FP32 multiplier arbiter slice:
// FP32 field widths, the rounding-mode type and encodings, and the
// arbiter FSM state enum.
package fp_pkg;

  localparam int FP_SIGN_W = 1;
  localparam int FP_EXP_W  = 8;
  localparam int FP_MAN_W  = 23;
  localparam int FP_W      = FP_SIGN_W + FP_EXP_W + FP_MAN_W;

  // Rounding mode. Unlisted encodings round to nearest-even.
  typedef logic [2:0] rmode_t;
  localparam rmode_t RM_RNE = 3'b000;  // nearest, ties to even
  localparam rmode_t RM_RTZ = 3'b001;  // toward zero
  localparam rmode_t RM_RUP = 3'b010;  // toward +infinity
  localparam rmode_t RM_RDN = 3'b011;  // toward -infinity
  localparam rmode_t RM_RNA = 3'b100;  // nearest, ties away from zero

  localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/fp_mul_arbiter_if.sv
// Request/response bundle between two requesters and fp_mul_arbiter.
//   req_valid/req_ready : per-requester operation handshake (index 0/1)
//   req_x/req_y         : per-requester FP32 operands
//   req_rmode           : per-requester rounding mode
//   rsp_valid/rsp_ready : per-requester result handshake
//   rsp_z/rsp_ovrf/rsp_udrf : shared result, qualified by rsp_valid
// master = requester side, slave = arbiter side.
interface fp_mul_arbiter_if;

  logic [1:0]                req_valid;
  logic [1:0]                req_ready;
  logic [1:0][31:0]          req_x;
  logic [1:0][31:0]          req_y;
  fp_pkg::rmode_t [1:0]      req_rmode;
  logic [1:0]                rsp_valid;
  logic [1:0]                rsp_ready;
  logic [31:0]               rsp_z;
  logic                      rsp_ovrf;
  logic                      rsp_udrf;

  modport master (
    output req_valid, req_x, req_y, req_rmode, rsp_ready,
    input  req_ready, rsp_valid, rsp_z, rsp_ovrf, rsp_udrf
  );

  modport slave (
    input  req_valid, req_x, req_y, req_rmode, rsp_ready,
    output req_ready, rsp_valid, rsp_z, rsp_ovrf, rsp_udrf
  );

endinterface

// File: rtl/fp_mul.sv
// Combinational FP32 multiplier.
//   fp_X, fp_Y : operands          r_mode : rounding mode (fp_pkg RM_*)
//   fp_Z       : product           ovrf/udrf : overflow / underflow flags
// Subnormal inputs are treated as zero and results below the normal range
// flush to signed zero with udrf set. Overflow saturates to infinity or the
// largest finite value depending on the rounding direction. NaN inputs and
// inf*0 give a quiet NaN. The datapath is symmetric in fp_X/fp_Y.
module fp_mul
  import fp_pkg::*;
(
  input  logic [31:0] fp_X,
  input  logic [31:0] fp_Y,
  input  rmode_t      r_mode,
  output logic [31:0] fp_Z,
  output logic        ovrf,
  output logic        udrf
);

  logic                  sign;
  logic [FP_EXP_W-1:0]   ea, eb;
  logic [FP_MAN_W-1:0]   fa, fb;
  logic                  a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [47:0]           prod;
  logic                  norm, guard, sticky, inc, ovf_to_inf;
  logic [FP_MAN_W-1:0]   mant;
  logic [FP_MAN_W:0]     mant_r;
  logic signed [9:0]     exp_s;

  // NOTE: every variable written here gets a value on every path (defaults
  // first), otherwise synthesis infers latches.
  always_comb begin
    sign   = fp_X[31] ^ fp_Y[31];
    ea     = fp_X[30:23];
    eb     = fp_Y[30:23];
    fa     = fp_X[FP_MAN_W-1:0];
    fb     = fp_Y[FP_MAN_W-1:0];
    a_zero = (ea == 8'h00);
    b_zero = (eb == 8'h00);
    a_inf  = (ea == 8'hFF) && (fa == '0);
    b_inf  = (eb == 8'hFF) && (fb == '0);
    a_nan  = (ea == 8'hFF) && (fa != '0);
    b_nan  = (eb == 8'hFF) && (fb != '0);

    prod = {24'd0, 1'b1, fa} * {24'd0, 1'b1, fb};
    // Product of two [1,2) significands lies in [1,4): bit 47 selects the
    // binade and shifts the round/sticky window by one.
    norm = prod[47];
    if (norm) begin
      mant   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
    end else begin
      mant   = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end

    case (r_mode)
      RM_RTZ:  begin inc = 1'b0;                     ovf_to_inf = 1'b0;  end
      RM_RUP:  begin inc = ~sign & (guard | sticky); ovf_to_inf = ~sign; end
      RM_RDN:  begin inc = sign & (guard | sticky);  ovf_to_inf = sign;  end
      RM_RNA:  begin inc = guard;                    ovf_to_inf = 1'b1;  end
      default: begin inc = guard & (sticky | mant[0]); ovf_to_inf = 1'b1; end
    endcase

    // A rounding carry out of the mantissa bumps the exponent; the stored
    // fraction is then all zeros, which mant_r[22:0] already holds.
    mant_r = {1'b0, mant} + {{FP_MAN_W{1'b0}}, inc};
    exp_s  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127
           + $signed({9'd0, norm}) + $signed({9'd0, mant_r[FP_MAN_W]});

    fp_Z = {sign, exp_s[7:0], mant_r[FP_MAN_W-1:0]};
    ovrf = 1'b0;
    udrf = 1'b0;
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
      fp_Z = FP_QNAN;
    end else if (a_inf || b_inf) begin
      fp_Z = {sign, 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      fp_Z = {sign, 31'd0};
    end else if (exp_s >= 10'sd255) begin
      ovrf = 1'b1;
      fp_Z = ovf_to_inf ? {sign, 8'hFF, 23'd0} : {sign, 8'hFE, 23'h7F_FFFF};
    end else if (exp_s <= 10'sd0) begin
      udrf = 1'b1;
      fp_Z = {sign, 31'd0};
    end
  end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Time-shares one fp_mul between two requesters with round-robin grant.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fp_mul_arbiter_if.slave (request/response handshakes)
//   stat_ops   : accepts per requester        (only with FP_MUL_ARB_STATS_EN)
//   stat_ovf   : completed responses with ovrf (only with FP_MUL_ARB_STATS_EN)
// Operation: IDLE accepts one request and registers its operands, CALC
// evaluates fp_mul from those registers and captures the result, RESP holds
// the result until the owner takes it. Accept at cycle N gives rsp_valid at
// N+2; at most one operation per three cycles.
module fp_mul_arbiter
  import fp_pkg::*;
#(
  parameter int STAT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
`ifdef FP_MUL_ARB_STATS_EN
  output logic [1:0][STAT_W-1:0] stat_ops,
  output logic [STAT_W-1:0]      stat_ovf,
`endif
  fp_mul_arbiter_if.slave        bus
);

  arb_state_e  state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] x_q, x_d, y_q, y_d;
  rmode_t      rmode_q, rmode_d;
  logic [31:0] z_q, z_d;
  logic        ovrf_q, ovrf_d, udrf_q, udrf_d;
  logic [1:0]  rsp_valid_q, rsp_valid_d;

  logic [31:0] mul_z;
  logic        mul_ovrf, mul_udrf;
  logic [1:0]  grant;
  logic        grant_idx, accept, complete;

  fp_mul u_fp_mul (
    .fp_X   (x_q),
    .fp_Y   (y_q),
    .r_mode (rmode_q),
    .fp_Z   (mul_z),
    .ovrf   (mul_ovrf),
    .udrf   (mul_udrf)
  );

  // Round-robin: a lone requester wins; on a tie the one that did not win
  // last time wins. Grant is offered only in IDLE and never during reset.
  always_comb begin
    case (bus.req_valid)
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = ~last_grant_q;
      default: grant_idx = 1'b0;
    endcase
    grant = 2'b00;
    if ((state_q == ST_IDLE) && rst_n && (bus.req_valid != 2'b00)) begin
      grant[grant_idx] = 1'b1;
    end
  end

  assign accept   = |grant;
  assign complete = (state_q == ST_RESP) && bus.rsp_ready[owner_q];

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    x_d          = x_q;
    y_d          = y_q;
    rmode_d      = rmode_q;
    z_d          = z_q;
    ovrf_d       = ovrf_q;
    udrf_d       = udrf_q;
    rsp_valid_d  = rsp_valid_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        state_d      = ST_CALC;
        owner_d      = grant_idx;
        last_grant_d = grant_idx;
        x_d          = bus.req_x[grant_idx];
        y_d          = bus.req_y[grant_idx];
        rmode_d      = bus.req_rmode[grant_idx];
      end
      ST_CALC: begin
        state_d     = ST_RESP;
        z_d         = mul_z;
        ovrf_d      = mul_ovrf;
        udrf_d      = mul_udrf;
        rsp_valid_d = owner_q ? 2'b10 : 2'b01;
      end
      ST_RESP: if (complete) begin
        state_d     = ST_IDLE;
        rsp_valid_d = 2'b00;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  // Operand and result registers are reset too: their values are visible on
  // rsp_z and at the multiplier inputs straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;  // requester 0 wins the first tie
      x_q          <= '0;
      y_q          <= '0;
      rmode_q      <= '0;
      z_q          <= '0;
      ovrf_q       <= 1'b0;
      udrf_q       <= 1'b0;
      rsp_valid_q  <= 2'b00;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      x_q          <= x_d;
      y_q          <= y_d;
      rmode_q      <= rmode_d;
      z_q          <= z_d;
      ovrf_q       <= ovrf_d;
      udrf_q       <= udrf_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

  assign bus.req_ready = grant;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_z     = z_q;
  assign bus.rsp_ovrf  = ovrf_q;
  assign bus.rsp_udrf  = udrf_q;

`ifdef FP_MUL_ARB_STATS_EN
  logic [1:0][STAT_W-1:0] stat_ops_q, stat_ops_d;
  logic [STAT_W-1:0]      stat_ovf_q, stat_ovf_d;

  // Saturating counters: hold at all-ones instead of wrapping.
  always_comb begin
    stat_ops_d = stat_ops_q;
    stat_ovf_d = stat_ovf_q;
    if (accept && (stat_ops_q[grant_idx] != '1)) begin
      stat_ops_d[grant_idx] = stat_ops_q[grant_idx] + STAT_W'(1);
    end
    if (complete && ovrf_q && (stat_ovf_q != '1)) begin
      stat_ovf_d = stat_ovf_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops_q <= '0;
      stat_ovf_q <= '0;
    end else begin
      stat_ops_q <= stat_ops_d;
      stat_ovf_q <= stat_ovf_d;
    end
  end

  assign stat_ops = stat_ops_q;
  assign stat_ovf = stat_ovf_q;
`endif

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter. Inputs change on the falling edge and
// outputs are sampled 1 time unit later, away from the rising edge.
module tb_fp_mul_arbiter;
  import fp_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  fp_mul_arbiter_if bus ();

`ifdef FP_MUL_ARB_STATS_EN
  logic [1:0][15:0] stat_ops;
  logic [15:0]      stat_ovf;
`endif

  fp_mul_arbiter #(.STAT_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef FP_MUL_ARB_STATS_EN
    .stat_ops (stat_ops),
    .stat_ovf (stat_ovf),
`endif
    .bus      (bus)
  );

  task automatic idle_inputs();
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.req_rmode = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One complete transaction with fixed timing: accept at the next rising
  // edge (cycle N), CALC at N+1, response at N+2, handshake immediately.
  task automatic do_op(input bit idx, input logic [31:0] x, input logic [31:0] y,
                       input rmode_t rm, input logic [31:0] exp_z,
                       input logic exp_ov, input logic exp_uf, input string name);
    logic [1:0] own;
    own = idx ? 2'b10 : 2'b01;
    @(negedge clk);
    bus.req_valid[idx] = 1'b1;
    bus.req_x[idx]     = x;
    bus.req_y[idx]     = y;
    bus.req_rmode[idx] = rm;
    #1;
    checks++; if (bus.req_ready !== own) begin errors++; $display("FAIL %s req_ready got %b want %b", name, bus.req_ready, own); end
    @(negedge clk);
    bus.req_valid[idx] = 1'b0;
    #1;
    checks++; if (bus.rsp_valid !== 2'b00 || bus.req_ready !== 2'b00) begin errors++; $display("FAIL %s calc_cycle rsp_valid=%b req_ready=%b want 00/00", name, bus.rsp_valid, bus.req_ready); end
    @(negedge clk);
    #1;
    checks++; if (bus.rsp_valid !== own) begin errors++; $display("FAIL %s rsp_valid got %b want %b", name, bus.rsp_valid, own); end
    checks++; if (bus.rsp_z !== exp_z) begin errors++; $display("FAIL %s rsp_z got %h want %h", name, bus.rsp_z, exp_z); end
    checks++; if ({bus.rsp_ovrf, bus.rsp_udrf} !== {exp_ov, exp_uf}) begin errors++; $display("FAIL %s flags got %b%b want %b%b", name, bus.rsp_ovrf, bus.rsp_udrf, exp_ov, exp_uf); end
    bus.rsp_ready[idx] = 1'b1;
    @(negedge clk);
    bus.rsp_ready[idx] = 1'b0;
    #1;
    checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL %s rsp_valid_after got %b want 00", name, bus.rsp_valid); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    bus.req_valid = 2'b11;
    #1;
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b want 00", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b want 00", bus.rsp_valid); end
    checks++; if ({bus.rsp_z, bus.rsp_ovrf, bus.rsp_udrf} !== 34'd0) begin errors++; $display("FAIL reset_rsp_data got %h/%b%b want 0", bus.rsp_z, bus.rsp_ovrf, bus.rsp_udrf); end
`ifdef FP_MUL_ARB_STATS_EN
    checks++; if (stat_ops !== 32'd0 || stat_ovf !== 16'd0) begin errors++; $display("FAIL reset_stats got %h/%h want 0", stat_ops, stat_ovf); end
`endif
    bus.req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    do_op(1'b0, 32'h4000_0000, 32'h4040_0000, RM_RNE, 32'h40C0_0000, 1'b0, 1'b0, "basic_2x3");
    do_op(1'b0, 32'hC000_0000, 32'h4080_0000, RM_RNE, 32'hC100_0000, 1'b0, 1'b0, "neg_2x4");
    // fp_mul flushes results below the normal range to zero and flags udrf
    do_op(1'b1, 32'h0080_0000, 32'h0080_0000, RM_RNE, 32'h0000_0000, 1'b0, 1'b1, "underflow");
  endtask

  task automatic test_tie();
    apply_reset();
    @(negedge clk);
    bus.req_valid = 2'b11;
    bus.req_x[0] = 32'h4000_0000; bus.req_y[0] = 32'h4040_0000; bus.req_rmode[0] = RM_RNE;
    bus.req_x[1] = 32'h3FC0_0000; bus.req_y[1] = 32'h4000_0000; bus.req_rmode[1] = RM_RNE;
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL tie_first_grant got %b want 01", bus.req_ready); end
    @(negedge clk);
    bus.req_valid[0] = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL tie_calc_ready got %b want 00", bus.req_ready); end
    @(negedge clk);
    bus.rsp_ready = 2'b10;  // non-owner ready must be ignored
    #1;
    checks++; if (bus.rsp_valid !== 2'b01 || bus.rsp_z !== 32'h40C0_0000) begin errors++; $display("FAIL tie_rsp0 got %b/%h want 01/40c00000", bus.rsp_valid, bus.rsp_z); end
    @(negedge clk);
    #1;
    checks++; if (bus.rsp_valid !== 2'b01) begin errors++; $display("FAIL nonowner_ready_ignored rsp_valid got %b want 01", bus.rsp_valid); end
    bus.rsp_ready = 2'b01;
    @(negedge clk);
    bus.rsp_ready = 2'b00;
    #1;
    checks++; if (bus.req_ready !== 2'b10 || bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL tie_second_grant req_ready=%b rsp_valid=%b want 10/00", bus.req_ready, bus.rsp_valid); end
    @(negedge clk);
    bus.req_valid[1] = 1'b0;
    #1;
    checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL tie_calc1 rsp_valid got %b want 00", bus.rsp_valid); end
    @(negedge clk);
    #1;
    checks++; if (bus.rsp_valid !== 2'b10 || bus.rsp_z !== 32'h4040_0000) begin errors++; $display("FAIL tie_rsp1 got %b/%h want 10/40400000", bus.rsp_valid, bus.rsp_z); end
    bus.rsp_ready = 2'b10;
    @(negedge clk);
    bus.rsp_ready = 2'b00;
    bus.req_valid = 2'b11;
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL tie_third_grant got %b want 01", bus.req_ready); end
    bus.req_valid = 2'b00;
  endtask

  task automatic test_overflow();
    apply_reset();
    do_op(1'b1, 32'h7F00_0000, 32'h7F00_0000, RM_RNE, 32'h7F80_0000, 1'b1, 1'b0, "overflow");
`ifdef FP_MUL_ARB_STATS_EN
    checks++; if (stat_ovf !== 16'd1) begin errors++; $display("FAIL stat_ovf got %0d want 1", stat_ovf); end
    checks++; if (stat_ops[1] !== 16'd1 || stat_ops[0] !== 16'd0) begin errors++; $display("FAIL stat_ops got %0d/%0d want 0/1", stat_ops[0], stat_ops[1]); end
`endif
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    bus.req_valid[0] = 1'b1;
    bus.req_x[0] = 32'hC000_0000; bus.req_y[0] = 32'h4080_0000; bus.req_rmode[0] = RM_RNE;
    @(negedge clk);
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    bus.req_valid = 2'b10;  // competing request waits through RESP
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (bus.rsp_valid !== 2'b01 || bus.rsp_z !== 32'hC100_0000 || {bus.rsp_ovrf, bus.rsp_udrf} !== 2'b00 || bus.req_ready !== 2'b00)
        begin errors++; $display("FAIL hold_cycle%0d rsp_valid=%b z=%h flags=%b%b req_ready=%b want 01/c1000000/00/00", i, bus.rsp_valid, bus.rsp_z, bus.rsp_ovrf, bus.rsp_udrf, bus.req_ready); end
      @(negedge clk);
    end
    bus.rsp_ready[0] = 1'b1;
    @(negedge clk);
    bus.rsp_ready[0] = 1'b0;
    #1;
    checks++; if (bus.rsp_valid !== 2'b00 || bus.req_ready !== 2'b10) begin errors++; $display("FAIL hold_release rsp_valid=%b req_ready=%b want 00/10", bus.rsp_valid, bus.req_ready); end
    bus.req_valid = 2'b00;
  endtask

  task automatic test_reset_in_calc();
    @(negedge clk);
    bus.req_valid[0] = 1'b1;
    bus.req_x[0] = 32'h4000_0000; bus.req_y[0] = 32'h4040_0000; bus.req_rmode[0] = RM_RNE;
    @(negedge clk);
    bus.req_valid[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.rsp_valid !== 2'b00 || bus.req_ready !== 2'b00) begin errors++; $display("FAIL calc_reset rsp_valid=%b req_ready=%b want 00/00", bus.rsp_valid, bus.req_ready); end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL calc_reset_release rsp_valid got %b want 00", bus.rsp_valid); end
    do_op(1'b1, 32'h3FC0_0000, 32'h4000_0000, RM_RNE, 32'h4040_0000, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_swap();
    logic [31:0] exp_z;
    for (int m = 0; m < 8; m++) begin
      // |product| = 1 + 2^-24 - 2^-47, just under half an ulp above 1.0;
      // only round-toward-minus-infinity moves the negative result away.
      exp_z = (m == 3) ? 32'hBF80_0001 : 32'hBF80_0000;
      do_op(1'b0, 32'h3F80_0001, 32'hBF7F_FFFF, rmode_t'(m), exp_z, 1'b0, 1'b0, $sformatf("swap_xy_rm%0d", m));
      do_op(1'b1, 32'hBF7F_FFFF, 32'h3F80_0001, rmode_t'(m), exp_z, 1'b0, 1'b0, $sformatf("swap_yx_rm%0d", m));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_overflow();
    test_backpressure();
    test_reset_in_calc();
    test_swap();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout after %0d checks", checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fp_mul_arbiter.md
FP_MUL_ARBITER -- requirements
Module: fp_mul_arbiter

Interface
REQ-001 The block SHALL have parameter STAT_W, default 16: width of statistics counters (used only under REQ-024).
REQ-002 The block SHALL have port clk  input  1  single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port req_valid  input  2  per-requester operation valid, index 0/1.
REQ-005 The block SHALL have port req_ready  output  2  per-requester accept.
REQ-006 The block SHALL have port req_x, req_y  input  2x32  per-requester FP32 operands.
REQ-007 The block SHALL have port req_rmode  input  2x3  per-requester rounding mode, passed unchanged to r_mode.
REQ-008 The block SHALL have port rsp_valid  output  2  per-requester result valid.
REQ-009 The block SHALL have port rsp_ready  input  2  per-requester result accept.
REQ-010 The block SHALL have port rsp_z  output  32  result, shared by both requesters and qualified by rsp_valid.
REQ-011 The block SHALL have port rsp_ovrf, rsp_udrf  output  1 each  flags, qualified by rsp_valid.

Function
REQ-012 The block SHALL time-share one fp_mul instance between two requesters.
REQ-013 The FSM SHALL have states IDLE, CALC and RESP.
  - IDLE->CALC on accept.
  - CALC->RESP unconditionally after one cycle.
  - RESP->IDLE when rsp_valid[owner] && rsp_ready[owner].
REQ-014 In IDLE, req_ready[i] SHALL be 1 only for the granted requester i; it SHALL be 0 in CALC and RESP.
REQ-015 Accept SHALL occur when req_valid[i] && req_ready[i]. On accept, the block SHALL:
  - register x, y and rmode into operand registers;
  - record the owner index.
REQ-016 Arbitration SHALL be round-robin.
  - If only one requester is valid, it is granted.
  - If both are valid, the requester other than last_grant is granted.
  - last_grant updates on accept only.
REQ-017 The fp_mul inputs SHALL come from the operand registers only. At the end of CALC, fp_Z, ovrf and udrf SHALL be captured into result registers.
REQ-018 Latency SHALL be fixed: accept at cycle N, rsp_valid[owner]=1 from cycle N+2.
REQ-019 Throughput SHALL be at most one operation per 3 cycles. No new accept is allowed before the response handshake completes.
REQ-020 During RESP, rsp_valid[owner] SHALL stay 1, and rsp_z and the flags SHALL stay stable until rsp_ready[owner].
  - rsp_valid of the non-owner SHALL stay 0.
  - rsp_ready of the non-owner SHALL be ignored.
REQ-021 The result SHALL be bit-identical to fp_mul on the same operands. Swapping x and y SHALL give an identical rsp_z and identical flags.

Reset
REQ-022 On rst_n=0, the block SHALL asynchronously reset to:
  - state IDLE, last_grant=1 (requester 0 wins the first tie);
  - req_ready=0 while in reset;
  - rsp_valid=0, rsp_z=0, rsp_ovrf=0, rsp_udrf=0;
  - operand registers 0.
REQ-023 Reset asserted in CALC or RESP SHALL discard the in-flight operation with no response. The first cycle after reset release SHALL behave as IDLE.

Configuration
REQ-024 With FP_MUL_ARB_STATS_EN defined, the block SHALL add these outputs:
  - stat_ops output 2xSTAT_W: accepts per requester;
  - stat_ovf output STAT_W: completed responses with ovrf=1.
  Each counter saturates at all-ones and resets to 0.
REQ-025 Without FP_MUL_ARB_STATS_EN, those ports and counters SHALL NOT exist, and the remaining behaviour SHALL be identical.

Structure
REQ-026 Package fp_pkg SHALL hold:
  - FP32 field-width constants (1/8/23);
  - rmode_t (3-bit rounding-mode typedef);
  - the arbiter state enum.
REQ-027 fp_mul SHALL be the only sub-module, instantiated once. Arbitration and FSM logic SHALL be inline.

Verification
REQ-028 Requester 0 sends x=0x40000000, y=0x40400000, rmode=000 -> rsp_valid[0] at N+2, rsp_z=0x40C00000, ovrf=udrf=0.
REQ-029 Both requesters are valid in the same cycle after reset -> requester 0 is served first. Requester 1 is then accepted in the first IDLE cycle after requester 0's handshake. The next tie goes to requester 0.
REQ-030 Requester 1 sends x=y=0x7F000000, rmode=000 -> rsp_z=0x7F800000, rsp_ovrf=1. Under STATS_EN, stat_ovf increments by 1.
REQ-031 rsp_ready[0] is held 0 for 5 cycles during RESP -> rsp_valid[0], rsp_z and the flags are stable, req_ready=00 throughout, and the block completes on the release of rsp_ready.
REQ-032 rst_n is pulsed low during CALC -> rsp_valid stays 0, no response appears, and a new request is accepted on the first cycle after release.
REQ-033 The same operands are sent in swapped order on the two requesters (0x3F800001, 0xBF7FFFFF, every rmode) -> the two responses are bit-identical.
